// File: rtl/dot_product_feeder_pkg.sv
// Shared types and constants for the dot-product feeder and its floating-point multiplier.
package dot_product_feeder_pkg;

  localparam int MAX_DATA_WIDTH = 128;

  // All-zero pattern is +0.0 for any sign/exponent/fraction split; sliced to the active width.
  localparam logic [MAX_DATA_WIDTH-1:0] FP_POS_ZERO_WIDE = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ZERO = 2'd2
  } state_t;

  function automatic int data_width(input int frac_width, input int exp_width);
    return frac_width + exp_width;
  endfunction

endpackage

// File: rtl/floating_point_mult.sv
// Pipelined FP multiplier: sign|exp|fraction format, RNE rounding, denormals flushed to zero.
// Latency MUL_LATENCY (>= 2) cycles, one operation per cycle, no backpressure; dataOut is 0 when validOut is low.
module floating_point_mult
  import dot_product_feeder_pkg::*;
#(
  parameter int FRAC_WIDTH  = 24,
  parameter int EXP_WIDTH   = 8,
  parameter int MUL_LATENCY = 6
) (
  input  logic                            clkIn,
  input  logic                            rstIn,
  input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataAIn,
  input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataBIn,
  input  logic                            validIn,
  output logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataOut,
  output logic                            validOut
);

  localparam int DW = data_width(FRAC_WIDTH, EXP_WIDTH);
  localparam int MW = FRAC_WIDTH - 1;
  localparam int PW = 2 * FRAC_WIDTH;
  localparam int XW = EXP_WIDTH + 2;

  localparam logic [EXP_WIDTH-1:0] EXP_MAX  = '1;
  localparam logic signed [XW-1:0] BIAS     = {3'b000, {(EXP_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] EXP_SAT  = {2'b00, EXP_MAX};
  localparam logic signed [XW-1:0] X_ONE    = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] X_ZERO   = '0;

  logic                 sa, sb;
  logic [EXP_WIDTH-1:0] ea, eb;
  logic [MW-1:0]        fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0]        ma_ext, mb_ext;

  assign {sa, ea, fa} = dataAIn;
  assign {sb, eb, fb} = dataBIn;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_MAX) && (fa == '0);
  assign b_inf  = (eb == EXP_MAX) && (fb == '0);
  assign a_nan  = (ea == EXP_MAX) && (fa != '0);
  assign b_nan  = (eb == EXP_MAX) && (fb != '0);
  assign ma_ext = {{FRAC_WIDTH{1'b0}}, 1'b1, fa};
  assign mb_ext = {{FRAC_WIDTH{1'b0}}, 1'b1, fb};

  // Stage 1: unpack, classify, full-width significand product and biased exponent sum.
  logic                 s1_vld;
  logic                 s1_sign, s1_zero, s1_inf, s1_nan;
  logic signed [XW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) s1_vld <= 1'b0;
    else       s1_vld <= validIn;
  end

  always_ff @(posedge clkIn) begin
    s1_sign <= sa ^ sb;
    s1_zero <= a_zero | b_zero;
    s1_inf  <= a_inf | b_inf;
    s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    s1_exp  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    s1_prod <= ma_ext * mb_ext;
  end

  // Stage 2: normalise by at most one position, round to nearest even, then saturate or flush.
  logic                 hi;
  logic [MW-1:0]        mant;
  logic                 guard, sticky, round_up;
  logic [MW:0]          mant_r;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [DW-1:0]        result;

  assign hi       = s1_prod[PW-1];
  assign mant     = hi ? s1_prod[PW-2 -: MW] : s1_prod[PW-3 -: MW];
  assign guard    = hi ? s1_prod[PW-2-MW] : s1_prod[PW-3-MW];
  assign sticky   = hi ? (|s1_prod[PW-3-MW:0]) : (|s1_prod[PW-4-MW:0]);
  assign round_up = guard & (sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + {{MW{1'b0}}, round_up};
  assign exp_n    = hi ? (s1_exp + X_ONE) : s1_exp;
  assign exp_r    = exp_n + (mant_r[MW] ? X_ONE : X_ZERO);

  always_comb begin
    result = {s1_sign, exp_r[EXP_WIDTH-1:0], mant_r[MW-1:0]};
    if (s1_nan)
      result = {1'b0, EXP_MAX, 1'b1, {(MW-1){1'b0}}};
    else if (s1_inf || (!s1_zero && exp_r >= EXP_SAT))
      result = {s1_sign, EXP_MAX, {MW{1'b0}}};
    else if (s1_zero || exp_r <= X_ZERO)
      result = {s1_sign, {(DW-1){1'b0}}};
  end

  logic          s2_vld;
  logic [DW-1:0] s2_dat;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) s2_vld <= 1'b0;
    else       s2_vld <= s1_vld;
  end

  always_ff @(posedge clkIn) begin
    s2_dat <= result;
  end

  logic          out_vld;
  logic [DW-1:0] out_dat;

  generate
    if (MUL_LATENCY > 2) begin : g_dly
      logic [MUL_LATENCY-3:0] dly_vld;
      logic [DW-1:0]          dly_dat [MUL_LATENCY-2];

      always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
          dly_vld <= '0;
        end else begin
          dly_vld[0] <= s2_vld;
          for (int i = 1; i < MUL_LATENCY - 2; i++) dly_vld[i] <= dly_vld[i-1];
        end
      end

      always_ff @(posedge clkIn) begin
        dly_dat[0] <= s2_dat;
        for (int i = 1; i < MUL_LATENCY - 2; i++) dly_dat[i] <= dly_dat[i-1];
      end

      assign out_vld = dly_vld[MUL_LATENCY-3];
      assign out_dat = dly_dat[MUL_LATENCY-3];
    end else begin : g_nodly
      assign out_vld = s2_vld;
      assign out_dat = s2_dat;
    end
  endgenerate

  assign validOut = out_vld;
  assign dataOut  = out_vld ? out_dat : '0;

endmodule

// File: rtl/dot_product_feeder.sv
// Start/len FSM streaming A*B pairs through floating_point_mult; DOT_PRODUCT_FEEDER_ZERO_LEN_EN makes len=0 emit one +0.0 last product.
// Accept-to-product latency MUL_LATENCY (>= 2); readyOut only in RUN, product stream has no backpressure.
module dot_product_feeder
  import dot_product_feeder_pkg::*;
#(
  parameter int FRAC_WIDTH  = 24,
  parameter int EXP_WIDTH   = 8,
  parameter int LEN_WIDTH   = 16,
  parameter int MUL_LATENCY = 6
) (
  input  logic                            clkIn,
  input  logic                            rstIn,
  input  logic                            startIn,
  input  logic [LEN_WIDTH-1:0]            lenIn,
  output logic                            busyOut,
  input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataAIn,
  input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataBIn,
  input  logic                            validIn,
  output logic                            readyOut,
  output logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataOut,
  output logic                            validOut,
  output logic                            lastOut
);

  localparam int DATA_WIDTH = data_width(FRAC_WIDTH, EXP_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ZERO_PROD = FP_POS_ZERO_WIDE[DATA_WIDTH-1:0];
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [LEN_WIDTH-1:0]    cnt;
  logic                    ready_r;
  logic                    accept, zero_inj, issue_vld, issue_last;
  logic [DATA_WIDTH-1:0]   mul_a, mul_b, mul_dat;
  logic                    mul_vld;
  logic [MUL_LATENCY-1:0]  tag_vld, tag_last;

  assign accept = validIn & ready_r;

`ifdef DOT_PRODUCT_FEEDER_ZERO_LEN_EN
  assign zero_inj = (state == ST_ZERO);
`else
  assign zero_inj = 1'b0;
`endif

  assign issue_vld  = accept | zero_inj;
  assign issue_last = accept ? (cnt == '0) : zero_inj;
  // Both operands are forced so the injected product is exactly +0.0 whatever sits on the data inputs.
  assign mul_a      = zero_inj ? ZERO_PROD : dataAIn;
  assign mul_b      = zero_inj ? ZERO_PROD : dataBIn;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (startIn && lenIn != '0) begin
            cnt     <= lenIn - LEN_ONE;
            state   <= ST_RUN;
            ready_r <= 1'b1;
          end
`ifdef DOT_PRODUCT_FEEDER_ZERO_LEN_EN
          else if (startIn) begin
            state <= ST_ZERO;
          end
`endif
        end
        ST_RUN: begin
          if (accept) begin
            if (cnt == '0) begin
              state   <= ST_IDLE;
              ready_r <= 1'b0;
            end else begin
              cnt <= cnt - LEN_ONE;
            end
          end
        end
`ifdef DOT_PRODUCT_FEEDER_ZERO_LEN_EN
        ST_ZERO: state <= ST_IDLE;
`endif
        default: begin
          state   <= ST_IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  floating_point_mult #(
    .FRAC_WIDTH (FRAC_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH),
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mult (
    .clkIn   (clkIn),
    .rstIn   (rstIn),
    .dataAIn (mul_a),
    .dataBIn (mul_b),
    .validIn (issue_vld),
    .dataOut (mul_dat),
    .validOut(mul_vld)
  );

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      tag_vld  <= '0;
      tag_last <= '0;
    end else begin
      tag_vld  <= {tag_vld[MUL_LATENCY-2:0], issue_vld};
      tag_last <= {tag_last[MUL_LATENCY-2:0], issue_last};
    end
  end

  assign readyOut = ready_r;
  assign validOut = tag_vld[MUL_LATENCY-1] & mul_vld;
  assign lastOut  = validOut & tag_last[MUL_LATENCY-1];
  assign dataOut  = validOut ? mul_dat : ZERO_PROD;
  // A pending last tag keeps busy asserted until the vector's final product has left.
  assign busyOut  = (state != ST_IDLE) | (|tag_last);

endmodule

// File: tb/tb_dot_product_feeder.sv
// Directed bench for dot_product_feeder: per-cycle stimulus and hand-computed output tables per scenario.
module tb_dot_product_feeder;

  localparam int LW = 16;
  localparam int L  = 6;
  localparam int DW = 32;
  localparam int N  = 20;

  logic          clkIn = 1'b0;
  logic          rstIn, startIn, validIn;
  logic [LW-1:0] lenIn;
  logic [DW-1:0] dataAIn, dataBIn, dataOut;
  logic          busyOut, readyOut, validOut, lastOut;

  int vectors = 0;
  int miscompares = 0;

  logic          t_rst [N];
  logic          t_start [N];
  logic [LW-1:0] t_len [N];
  logic          t_vld [N];
  logic [DW-1:0] t_a [N];
  logic [DW-1:0] t_b [N];
  logic          x_rdy [N];
  logic          x_busy [N];
  logic          x_vld [N];
  logic          x_last [N];
  logic [DW-1:0] x_dat [N];

  dot_product_feeder #(
    .FRAC_WIDTH (24),
    .EXP_WIDTH  (8),
    .LEN_WIDTH  (LW),
    .MUL_LATENCY(L)
  ) dut (
    .clkIn   (clkIn),
    .rstIn   (rstIn),
    .startIn (startIn),
    .lenIn   (lenIn),
    .busyOut (busyOut),
    .dataAIn (dataAIn),
    .dataBIn (dataBIn),
    .validIn (validIn),
    .readyOut(readyOut),
    .dataOut (dataOut),
    .validOut(validOut),
    .lastOut (lastOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic clear_tables();
    for (int i = 0; i < N; i++) begin
      t_rst[i] = 1'b0; t_start[i] = 1'b0; t_len[i] = '0; t_vld[i] = 1'b0;
      t_a[i] = '0; t_b[i] = '0;
      x_rdy[i] = 1'b0; x_busy[i] = 1'b0; x_vld[i] = 1'b0; x_last[i] = 1'b0; x_dat[i] = '0;
    end
  endtask

  task automatic set_start(input int r, input logic [LW-1:0] len);
    t_start[r] = 1'b1;
    t_len[r]   = len;
  endtask

  task automatic set_pair(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
    t_vld[r] = 1'b1;
    t_a[r]   = a;
    t_b[r]   = b;
  endtask

  task automatic set_out(input int r, input logic [DW-1:0] d, input logic last);
    x_vld[r]  = 1'b1;
    x_last[r] = last;
    x_dat[r]  = d;
  endtask

  task automatic set_rdy(input int a, input int b);
    for (int i = a; i <= b; i++) x_rdy[i] = 1'b1;
  endtask

  task automatic set_busy(input int a, input int b);
    for (int i = a; i <= b; i++) x_busy[i] = 1'b1;
  endtask

  task automatic apply_cycle(input int r);
    rstIn   = t_rst[r];
    startIn = t_start[r];
    lenIn   = t_len[r];
    validIn = t_vld[r];
    dataAIn = t_a[r];
    dataBIn = t_b[r];
    #1;
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clkIn);
    #1;
    vectors++;
    if ({readyOut, busyOut, validOut, lastOut, dataOut} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_held got rdy=%b busy=%b vld=%b last=%b dat=%h, want all 0",
               readyOut, busyOut, validOut, lastOut, dataOut);
    end
    rstIn = 1'b0;
    step();
    vectors++;
    if ({readyOut, busyOut, validOut, lastOut, dataOut} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_release got rdy=%b busy=%b vld=%b last=%b dat=%h, want all 0",
               readyOut, busyOut, validOut, lastOut, dataOut);
    end
    // Pairs offered in IDLE without a start must never be accepted.
    validIn = 1'b1; dataAIn = 32'h3F800000; dataBIn = 32'h3F800000;
    repeat (L + 2) step();
    validIn = 1'b0;
    vectors++;
    if ({readyOut, busyOut, validOut, lastOut, dataOut} !== 36'd0) begin
      miscompares++;
      $display("FAIL idle_valid got rdy=%b busy=%b vld=%b last=%b dat=%h, want all 0",
               readyOut, busyOut, validOut, lastOut, dataOut);
    end
  endtask

  task automatic test_basic();
    clear_tables();
    set_start(0, 16'd3);
    set_pair(1, 32'h3F800000, 32'h40000000);
    set_pair(2, 32'h40400000, 32'h40000000);
    set_pair(3, 32'h40000000, 32'h40000000);
    set_rdy(1, 3);
    set_busy(1, 9);
    set_out(7, 32'h40000000, 1'b0);
    set_out(8, 32'h40C00000, 1'b0);
    set_out(9, 32'h40800000, 1'b1);
    for (int r = 0; r < 12; r++) begin
      apply_cycle(r);
      vectors++;
      if ({readyOut, busyOut, validOut, lastOut, dataOut} !== {x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]}) begin
        miscompares++;
        $display("FAIL basic cyc %0d got rdy=%b busy=%b vld=%b last=%b dat=%h, want %b %b %b %b %h",
                 r, readyOut, busyOut, validOut, lastOut, dataOut, x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]);
      end
      step();
    end
  endtask

  task automatic test_gapped();
    clear_tables();
    set_start(0, 16'd4);
    set_pair(1, 32'h3F800000, 32'h3F800000);
    set_pair(2, 32'h40000000, 32'h40400000);
    set_pair(5, 32'hBFC00000, 32'h40000000);
    set_pair(6, 32'h3F000000, 32'h40800000);
    set_rdy(1, 6);
    set_busy(1, 12);
    set_out(7,  32'h3F800000, 1'b0);
    set_out(8,  32'h40C00000, 1'b0);
    set_out(11, 32'hC0400000, 1'b0);
    set_out(12, 32'h40000000, 1'b1);
    for (int r = 0; r < 15; r++) begin
      apply_cycle(r);
      vectors++;
      if ({readyOut, busyOut, validOut, lastOut, dataOut} !== {x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]}) begin
        miscompares++;
        $display("FAIL gapped cyc %0d got rdy=%b busy=%b vld=%b last=%b dat=%h, want %b %b %b %b %h",
                 r, readyOut, busyOut, validOut, lastOut, dataOut, x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    clear_tables();
    set_start(0, 16'd2);
    set_pair(1, 32'h40400000, 32'h40400000);
    set_pair(2, 32'h3F800001, 32'h3F800001);
    set_start(3, 16'd1);
    set_pair(4, 32'hC0000000, 32'hC0000000);
    set_rdy(1, 2);
    set_rdy(4, 4);
    set_busy(1, 10);
    set_out(7,  32'h41100000, 1'b0);
    set_out(8,  32'h3F800002, 1'b1);
    set_out(10, 32'h40800000, 1'b1);
    for (int r = 0; r < 13; r++) begin
      apply_cycle(r);
      vectors++;
      if ({readyOut, busyOut, validOut, lastOut, dataOut} !== {x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]}) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d got rdy=%b busy=%b vld=%b last=%b dat=%h, want %b %b %b %b %h",
                 r, readyOut, busyOut, validOut, lastOut, dataOut, x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]);
      end
      step();
    end
  endtask

  task automatic test_start_while_run();
    clear_tables();
    set_start(0, 16'd3);
    set_pair(1, 32'h3FC00000, 32'h3FC00000);
    set_start(1, 16'd9);
    set_pair(2, 32'hC0800000, 32'h3F000000);
    set_start(2, 16'd9);
    set_pair(3, 32'h3F800000, 32'h00000000);
    set_rdy(1, 3);
    set_busy(1, 9);
    set_out(7, 32'h40100000, 1'b0);
    set_out(8, 32'hC0000000, 1'b0);
    set_out(9, 32'h00000000, 1'b1);
    for (int r = 0; r < 13; r++) begin
      apply_cycle(r);
      vectors++;
      if ({readyOut, busyOut, validOut, lastOut, dataOut} !== {x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]}) begin
        miscompares++;
        $display("FAIL start_while_run cyc %0d got rdy=%b busy=%b vld=%b last=%b dat=%h, want %b %b %b %b %h",
                 r, readyOut, busyOut, validOut, lastOut, dataOut, x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]);
      end
      step();
    end
  endtask

  task automatic test_zero_len();
    clear_tables();
    set_start(0, 16'd0);
    // Unqualified -inf on the data inputs: an injected zero product must not pick it up.
    t_a[1] = 32'hFF800000;
    t_b[1] = 32'hFF800000;
`ifdef DOT_PRODUCT_FEEDER_ZERO_LEN_EN
    set_busy(1, 7);
    set_out(7, 32'h00000000, 1'b1);
`endif
    for (int r = 0; r < 10; r++) begin
      apply_cycle(r);
      vectors++;
      if ({readyOut, busyOut, validOut, lastOut, dataOut} !== {x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]}) begin
        miscompares++;
        $display("FAIL zero_len cyc %0d got rdy=%b busy=%b vld=%b last=%b dat=%h, want %b %b %b %b %h",
                 r, readyOut, busyOut, validOut, lastOut, dataOut, x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    clear_tables();
    set_start(0, 16'd5);
    set_pair(1, 32'h40000000, 32'h40000000);
    set_pair(2, 32'h40400000, 32'h40000000);
    set_pair(3, 32'h3F800000, 32'h3F800000);
    t_rst[3] = 1'b1;
    set_pair(4, 32'h3F800000, 32'h40000000);
    set_pair(5, 32'h3F800000, 32'h40000000);
    set_start(6, 16'd1);
    set_pair(7, 32'h40000000, 32'hC0400000);
    set_rdy(1, 2);
    set_rdy(7, 7);
    set_busy(1, 2);
    set_busy(7, 13);
    set_out(13, 32'hC0C00000, 1'b1);
    for (int r = 0; r < 16; r++) begin
      apply_cycle(r);
      vectors++;
      if ({readyOut, busyOut, validOut, lastOut, dataOut} !== {x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]}) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d got rdy=%b busy=%b vld=%b last=%b dat=%h, want %b %b %b %b %h",
                 r, readyOut, busyOut, validOut, lastOut, dataOut, x_rdy[r], x_busy[r], x_vld[r], x_last[r], x_dat[r]);
      end
      step();
    end
  endtask

  initial begin
    rstIn   = 1'b1;
    startIn = 1'b0;
    lenIn   = '0;
    validIn = 1'b0;
    dataAIn = '0;
    dataBIn = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_start_while_run();
    test_zero_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
